// File: rtl/pcim_stream_writer.sv
// AXI4 write master for the PCIM port: splits a programmed transfer into INCR bursts
// fed from a 512-bit stream and counts the write responses still owed.
module pcim_stream_writer #(
    parameter int DATA_W      = 512,
    parameter int ADDR_W      = 64,
    parameter int ID_W        = 16,
    parameter int AXI_ID      = 0,
    parameter int BURST_BEATS = 64,
    parameter int MAX_OUT     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [31:0]           cfg_num_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_W-1:0]     s_tdata,
    output logic [ID_W-1:0]       awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
    localparam logic [31:0] BURST_BEATS_C = 32'(BURST_BEATS);
    localparam int BEAT_SHIFT = 6;

    typedef enum logic [1:0] {IDLE, AW, W, WAIT_B} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cur_addr_reg, cur_addr_next;
    logic [31:0]         remaining_reg, remaining_next;
    logic [7:0]          burst_len_reg, burst_len_next;
    logic [7:0]          beat_cnt_reg, beat_cnt_next;
    logic [OUT_W-1:0]    outstanding_reg, outstanding_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;

    logic                aw_fire, w_fire, b_fire, b_count;
    logic [31:0]         beat_total, rem_after;
    logic                unused_bid;

    function automatic logic [7:0] first_len(input logic [31:0] rem);
        if (rem >= BURST_BEATS_C) return 8'(BURST_BEATS - 1);
        return 8'(rem - 32'd1);
    endfunction

    assign awid     = ID_W'(AXI_ID);
    assign awsize   = 3'b110;
    assign awaddr   = cur_addr_reg;
    assign awlen    = burst_len_reg;
    assign awvalid  = (state_reg == AW) && (outstanding_reg < MAX_OUT_C);
    assign wvalid   = (state_reg == W) && s_tvalid;
    assign s_tready = (state_reg == W) && wready;
    assign wdata    = s_tdata;
    assign wstrb    = '1;
    assign wlast    = (state_reg == W) && (beat_cnt_reg == burst_len_reg);
    assign bready   = 1'b1;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign err      = err_reg;

    assign aw_fire    = awvalid && awready;
    assign w_fire     = wvalid && wready;
    assign b_fire     = bvalid && bready;
    // A response with nothing outstanding is a slave protocol error; do not let it underflow
    assign b_count    = b_fire && (outstanding_reg != '0);
    assign beat_total = {24'd0, burst_len_reg} + 32'd1;
    assign rem_after  = remaining_reg - beat_total;
    assign unused_bid = ^bid;

    always_comb begin
        state_next       = state_reg;
        cur_addr_next    = cur_addr_reg;
        remaining_next   = remaining_reg;
        burst_len_next   = burst_len_reg;
        beat_cnt_next    = beat_cnt_reg;
        outstanding_next = outstanding_reg;
        done_next        = 1'b0;
        err_next         = err_reg;

        case ({aw_fire, b_count})
            2'b10:   outstanding_next = outstanding_reg + OUT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - OUT_W'(1);
            default: outstanding_next = outstanding_reg;
        endcase

        unique case (state_reg)
            IDLE: begin
                if (cfg_start) begin
                    cur_addr_next  = cfg_base_addr;
                    remaining_next = cfg_num_beats;
                    err_next       = 1'b0;
                    if (cfg_num_beats == 32'd0) begin
                        done_next = 1'b1;
                    end else begin
                        burst_len_next = first_len(cfg_num_beats);
                        state_next     = AW;
                    end
                end
            end
            AW: begin
                if (aw_fire) begin
                    beat_cnt_next = 8'd0;
                    state_next    = W;
                end
            end
            W: begin
                if (w_fire) begin
                    beat_cnt_next = beat_cnt_reg + 8'd1;
                    if (wlast) begin
                        remaining_next = rem_after;
                        cur_addr_next  = cur_addr_reg + (ADDR_W'(beat_total) << BEAT_SHIFT);
                        if (rem_after == 32'd0) begin
                            state_next = WAIT_B;
                        end else begin
                            burst_len_next = first_len(rem_after);
                            state_next     = AW;
                        end
                    end
                end
            end
            WAIT_B: begin
                if (outstanding_next == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Error responses are recorded in any state, after a start has cleared the flag
        if (b_fire && (bresp != 2'b00)) err_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cur_addr_reg    <= '0;
            remaining_reg   <= '0;
            burst_len_reg   <= '0;
            beat_cnt_reg    <= '0;
            outstanding_reg <= '0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cur_addr_reg    <= cur_addr_next;
            remaining_reg   <= remaining_next;
            burst_len_reg   <= burst_len_next;
            beat_cnt_reg    <= beat_cnt_next;
            outstanding_reg <= outstanding_next;
            done_reg        <= done_next;
            err_reg         <= err_next;
        end
    end
endmodule

// File: doc/pcim_stream_writer.md
# pcim_stream_writer

AXI4 write master that drains a 512-bit result stream into host memory over the PCIM interface. It sits downstream of the 64-to-512 width converter on the CL output path, in place of returning results through DMA PCIS read data. It cuts a software-programmed transfer into INCR bursts, issues address and data, tracks outstanding write responses, and reports completion and error.

## Interface
- DATA_W, 512: stream and W data width; fixed beat size 64 B.
- ADDR_W, 64: PCIM address width.
- ID_W, 16: AWID width.
- AXI_ID, 0: constant AWID driven on every burst.
- BURST_BEATS, 64: max beats per burst; BURST_BEATS*64 ≤ 4096.
- MAX_OUT, 4: max bursts awaiting B response.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle start pulse; ignored while busy.
- cfg_base_addr  in  ADDR_W  byte address; must be 4 KB aligned.
- cfg_num_beats  in  32  total 64 B beats to write.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky: some BRESP != OKAY; cleared by accepted cfg_start.
- s_tvalid / s_tready / s_tdata  in/out/in  1/1/DATA_W  input stream.
- awid/awaddr/awlen/awsize/awvalid  out  ID_W/ADDR_W/8/3/1  AW channel; awsize = 3'b110.
- awready  in  1.
- wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  W channel; wstrb all ones.
- wready  in  1.
- bid/bresp/bvalid  in  ID_W/2/1; bready  out  1, tied high.

## Operation
- States: IDLE, AW, W, WAIT_B.
- IDLE: accept cfg_start; latch cur_addr = cfg_base_addr, remaining = cfg_num_beats; clear err. If cfg_num_beats == 0: pulse done next cycle, stay IDLE. Otherwise go to AW and assert busy.
- AW: awvalid = (outstanding < MAX_OUT). awaddr = cur_addr; awlen = min(remaining, BURST_BEATS) − 1, latched as burst_len. On awvalid&awready: outstanding++, beat_cnt = 0, go to W.
- W: wvalid = s_tvalid; s_tready = wready (combinational pass-through); wdata = s_tdata; wlast = (beat_cnt == burst_len). Each handshake increments beat_cnt. On the wlast handshake: remaining −= burst_len+1; cur_addr += (burst_len+1)*64. Go to WAIT_B if remaining == 0, else AW.
- s_tready = 0 in every state except W.
- WAIT_B: stay until outstanding == 0, then go to IDLE; done pulses and busy drops.
- outstanding: +1 on AW fire, −1 on B fire; both in the same cycle leaves it unchanged. A B handshake with outstanding == 0 is a protocol violation and is ignored (no underflow).
- err is set on any B fire with bresp != 2'b00, including in IDLE.
- Bursts never cross 4 KB because the base is aligned and the burst size divides 4096. A final partial burst is shorter.
- AW is not issued before W data of the previous burst is complete; AW/W never overlap across bursts.

## Timing
- Reset values: awvalid = wvalid = s_tready = wlast = 0, busy = done = err = 0, bready = 1, awaddr = awlen = 0; state IDLE, counters 0.
- Reset asserted mid-transfer: all of the above take effect immediately and asynchronously. In-flight bursts are abandoned and no done is produced.
- cfg_start at cycle 0 → busy = 1 and awvalid = 1 at cycle 1, if MAX_OUT is not reached.
- AW handshake at cycle n → W state at n+1; the first W beat can complete at n+1.
- wlast handshake at cycle m → awvalid for the next burst at m+1 (AW state), subject to the outstanding limit.
- B handshake at cycle b that brings outstanding to 0 in WAIT_B → done = 1, busy = 0 at b+1.
- awvalid, once high, holds with stable awaddr/awlen until awready.
- wvalid follows s_tvalid with zero latency; no beat is dropped or duplicated under backpressure on either side.

## Test plan
- Single burst: base 0x1000, num_beats 64, awready/wready always 1 → one AW (awaddr 0x1000, awlen 63), 64 W beats, wlast on beat 64; after B OKAY, done at B+1.
- Multi-burst with partial tail: base 0x2000, num_beats 150 → AWs 0x2000/len 63, 0x3000/len 63, 0x4000/len 21; wlast on beats 64, 128 and 150.
- Outstanding limit: num_beats 640, MAX_OUT 4, bvalid withheld → exactly 4 AWs then awvalid stays 0. Release one B → fifth AW the next cycle.
- Backpressure: random s_tvalid and wready at 50% → data delivered in order, beat count exact, awaddr/awlen stable while awvalid & !awready.
- Error and zero length: bresp = SLVERR on burst 2 → err = 1 at completion; next cfg_start clears it. cfg_num_beats 0 → done pulse the next cycle, no AW issued.
- Reset mid-burst: assert rst_n low after beat 10 of burst 1 → all outputs at reset values immediately. A new start afterwards completes normally.
